// File: rtl/ext_fifo_prefill_gate.sv
// ext_fifo_prefill_gate
//
// Elastic stage sitting right after the external-SRAM FIFO on the int_clk
// side, feeding the TX DSP. Incoming 36-bit framed words are buffered in a
// small on-chip circular FIFO. Output is withheld (FILL) until either the
// occupancy reaches THRESHOLD or at least one complete packet (EOF) is held.
// From then on words stream (STREAM) until the buffer drains at a packet
// boundary. Running dry in the middle of a packet is reported as an underrun.
//
// Optional feature macro: PREFILL_STATS_EN
//   defined   -> underrun_count (saturating) and high_water (peak occupancy)
//   undefined -> both outputs tied to zero, no statistics registers
//
// Ports
//   clk            int_clk domain clock
//   rst            synchronous active-high reset
//   clear          synchronous flush, same effect as rst
//   datain         [31:0] payload, [32] SOF, [33] EOF, [35:34] sideband
//   src_rdy_i      upstream word valid
//   dst_rdy_o      buffer not full
//   dataout        head-of-buffer word (first-word-fall-through)
//   src_rdy_o      word presented (gate open and buffer non-empty)
//   dst_rdy_i      downstream accepts
//   occupancy      words held
//   underrun       one-cycle pulse on mid-packet starvation
//   underrun_count saturating underrun counter (stats build only)
//   high_water     peak occupancy since reset/clear (stats build only)

module ext_fifo_prefill_gate #(
    parameter int SIZE      = 6,
    parameter int THRESHOLD = 48
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [35:0]     datain,
    input  logic            src_rdy_i,
    output logic            dst_rdy_o,
    output logic [35:0]     dataout,
    output logic            src_rdy_o,
    input  logic            dst_rdy_i,
    output logic [SIZE:0]   occupancy,
    output logic            underrun,
    output logic [15:0]     underrun_count,
    output logic [SIZE:0]   high_water
);

    localparam int            DEPTH  = 1 << SIZE;
    localparam logic [SIZE:0] THRESH = (SIZE+1)'(THRESHOLD);
    localparam logic [SIZE:0] ONE    = (SIZE+1)'(1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t           state_reg, state_next;
    logic [35:0]      mem [DEPTH];
    logic [SIZE:0]    wr_ptr_reg, rd_ptr_reg;
    logic [SIZE:0]    eof_held_reg, eof_held_next;
    logic [SIZE:0]    occ_next;
    logic             in_pkt_reg;
    logic             armed_reg;
    logic             flush;
    logic             full, empty;
    logic             wr_en, rd_en;
    logic             wr_eof, rd_eof;

    assign flush = rst | clear;

    assign full  = (wr_ptr_reg[SIZE] != rd_ptr_reg[SIZE]) &&
                   (wr_ptr_reg[SIZE-1:0] == rd_ptr_reg[SIZE-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // No full-bypass: a read in the same cycle does not free a slot early.
    assign dst_rdy_o = ~full;
    assign wr_en     = src_rdy_i & ~full;
    assign rd_en     = src_rdy_o & dst_rdy_i;

    assign occupancy = wr_ptr_reg - rd_ptr_reg;

    // Head entry is read asynchronously so the word at rd_ptr is presented
    // without a read-latency bubble; a new word becomes visible the cycle
    // after its write.
    assign dataout = mem[rd_ptr_reg[SIZE-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[SIZE-1:0]] <= datain;
        end
    end

    assign wr_eof = wr_en & datain[33];
    assign rd_eof = rd_en & dataout[33];

    always_comb begin
        occ_next = occupancy;
        if (wr_en && !rd_en) begin
            occ_next = occupancy + ONE;
        end else if (rd_en && !wr_en) begin
            occ_next = occupancy - ONE;
        end
    end

    always_comb begin
        eof_held_next = eof_held_reg;
        if (wr_eof && !rd_eof) begin
            eof_held_next = eof_held_reg + ONE;
        end else if (rd_eof && !wr_eof) begin
            eof_held_next = eof_held_reg - ONE;
        end
    end

    // Pointers, packet tracking and underrun re-arm.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            eof_held_reg <= '0;
            in_pkt_reg   <= 1'b0;
            armed_reg    <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ONE;
                in_pkt_reg <= ~dataout[33];
            end
            eof_held_reg <= eof_held_next;
            // One pulse per starvation episode; the next read re-arms it.
            if (rd_en) begin
                armed_reg <= 1'b1;
            end else if (underrun) begin
                armed_reg <= 1'b0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (flush) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. The open condition looks at the values the registers
    // are about to take, so the word that meets the threshold is presented
    // on the very next cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                if ((occ_next >= THRESH) || (eof_held_next != '0)) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (empty && !in_pkt_reg) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // FSM: outputs
    always_comb begin
        src_rdy_o = 1'b0;
        underrun  = 1'b0;
        if (state_reg == STREAM) begin
            src_rdy_o = ~empty;
            underrun  = empty & in_pkt_reg & armed_reg & ~flush;
        end
    end

`ifdef PREFILL_STATS_EN
    logic [15:0]   underrun_count_reg;
    logic [SIZE:0] high_water_reg;

    always_ff @(posedge clk) begin
        if (flush) begin
            underrun_count_reg <= '0;
            high_water_reg     <= '0;
        end else begin
            if (underrun && (underrun_count_reg != 16'hFFFF)) begin
                underrun_count_reg <= underrun_count_reg + 16'd1;
            end
            if (occ_next > high_water_reg) begin
                high_water_reg <= occ_next;
            end
        end
    end

    assign underrun_count = underrun_count_reg;
    assign high_water     = high_water_reg;
`else
    assign underrun_count = '0;
    assign high_water     = '0;
`endif

endmodule
